hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter NREG, default 8: number of architectural registers; AW = clog2(NREG) is the register-address width.
REQ-002 Parameter DEPTH, default 3, minimum 3: number of tracked post-decode stages (0=EX, 1=MEM, 2=WB, >=3 write-back-complete).
REQ-003 Parameter FWD_EN, default 1: 1 = forwarding enabled; 0 = stall-only mode.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 issue  in  1  decode-stage instruction is valid and requests to advance.
REQ-007 rs_addr, rt_addr  in  AW each  decode-stage source registers.
REQ-008 rs_used, rt_used  in  1 each  source is actually read.
REQ-009 rd_addr  in  AW  decode-stage destination register.
REQ-010 rd_wr  in  1  decode-stage instruction writes rd_addr.
REQ-011 is_load  in  1  decode-stage instruction is a memory load; its result is available at MEM, not EX.
REQ-012 flush  in  1  taken branch/jump resolved; kills the decode instruction and stage 0.
REQ-013 hold  in  1  memory wait; freezes the whole tracked pipeline.
REQ-014 stall  out  1  decode must not advance; PC holds.
REQ-015 bubble  out  1  insert NOP into stage 0 this cycle.
REQ-016 fwd_rs_sel, fwd_rt_sel  out  2 each  0=register file, 1=EX, 2=MEM, 3=WB.
REQ-017 stall_cnt  out  16  saturating count of stalled issue cycles.

Function
REQ-018 Each stage entry shall hold {valid, rd (AW), load}; an entry is a producer only if valid=1.
REQ-019 Per used source, the matching stage shall be the youngest valid stage i with rd == source address; no register is hardwired to zero.
REQ-020 FWD_EN=1: a match at stage 0 with load=1 shall assert stall (load-use); otherwise sel = i+1 for i<=2, and sel=0 for i>=3 or no match.
REQ-021 FWD_EN=0: any match in stages 0..DEPTH-1 shall assert stall; sel shall be 0 always.
REQ-022 Unused sources (rs_used/rt_used=0) shall never cause a stall and shall give sel=0.
REQ-023 stall shall be combinational: (issue & hazard & ~flush) | hold.
REQ-024 bubble shall be combinational: ~hold & (stall | flush | ~issue).
REQ-025 When hold=1, all stage entries shall keep their values and stall_cnt shall not change.
REQ-026 When hold=0, stage[i] <= stage[i-1] for i>=1.
REQ-027 When hold=0, stage[0] <= {issue & rd_wr & ~stall & ~flush, rd_addr, is_load}.
REQ-028 flush with hold=0 shall also invalidate the entry currently in stage 0 before it moves to stage 1 (stage[1] <= invalid). Flush shall take priority over a simultaneous hazard.
REQ-029 flush and hold both asserted: hold wins; the flush shall be ignored by this block.
REQ-030 stall_cnt shall increment by 1 per cycle with issue=1, stall=1 and hold=0, and shall saturate at 16'hFFFF.
REQ-031 Latency: a producer issued in cycle N shall be visible for matching in cycle N+1.

Reset
REQ-032 rst_n low shall immediately clear all entry valid bits and clear stall_cnt to 0, independent of clk.
REQ-033 With no valid entries, the outputs shall be stall=hold, fwd selects=0, and bubble per REQ-024.
REQ-034 Reset asserted mid-stall shall drop any pending hazard; the first instruction after release shall see no producers.

Structure
REQ-035 A shared package shall hold the fwd_sel encodings (SEL_RF, SEL_EX, SEL_MEM, SEL_WB) and the stage-entry record type.
REQ-036 A single sub-module, hz_match, shall perform the youngest-match priority search for one source; it is instantiated twice (rs, rt).

Verification
REQ-037 Producer ADD r3 issued, next instruction reads rs=r3 -> stall=0, fwd_rs_sel=1; one idle cycle later -> fwd_rs_sel=2.
REQ-038 LD r2 issued, next instruction reads rt=r2 -> stall=1 for exactly one cycle and bubble=1; then fwd_rt_sel=2; stall_cnt=1.
REQ-039 FWD_EN=0, ADD r5 issued, next reads r5 -> stall for 3 cycles (DEPTH=3); afterward fwd_rs_sel=0.
REQ-040 Writes to r4 in stages 0 and 2, reader of r4 -> fwd_rs_sel=1 (youngest wins).
REQ-041 hold=1 for 5 cycles with LD r1 in stage 0 -> entries frozen, stall_cnt unchanged; on release a reader of r1 still stalls for one cycle.
REQ-042 flush concurrent with load-use hazard -> stall=0, bubble=1, stage 1 invalid next cycle; stall_cnt held at 16'hFFFF for 3 stalled cycles -> stays 16'hFFFF.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and encodings for the hazard scoreboard: forwarding-mux selects and the
// per-stage producer record.
package hazard_scoreboard_pkg;

   localparam logic [1:0] SEL_RF  = 2'd0;
   localparam logic [1:0] SEL_EX  = 2'd1;
   localparam logic [1:0] SEL_MEM = 2'd2;
   localparam logic [1:0] SEL_WB  = 2'd3;

   // Widest supported register address; narrower addresses are zero-extended into it.
   localparam int unsigned RD_W = 8;

   typedef struct packed {
      logic            valid;
      logic [RD_W-1:0] rd;
      logic            load;
   } stage_entry_t;

endpackage

// File: rtl/hazard_scoreboard_hz_match.sv
// Youngest-producer search for one source operand; turns the match position into a
// forwarding select or a stall request.
module hz_match
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned DEPTH  = 3,
   parameter int unsigned FWD_EN = 1
) (
   input  stage_entry_t [DEPTH-1:0] stages,
   input  logic [RD_W-1:0]          addr,
   input  logic                     used,
   output logic                     hazard,
   output logic [1:0]               sel
);

   logic        hit;
   int unsigned hit_idx;

   // Scanning oldest to youngest leaves the youngest match in hit_idx.
   always_comb begin
      hit     = 1'b0;
      hit_idx = 0;
      for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
         if (stages[i].valid && (stages[i].rd == addr)) begin
            hit     = 1'b1;
            hit_idx = i;
         end
      end
   end

   always_comb begin
      hazard = 1'b0;
      sel    = SEL_RF;
      if (used && hit) begin
         if (FWD_EN != 0) begin
            if ((hit_idx == 0) && stages[0].load) begin
               hazard = 1'b1;
            end else if (hit_idx <= 2) begin
               sel = 2'(hit_idx + 1);
            end
         end else begin
            hazard = 1'b1;
         end
      end
   end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage hazard scoreboard: tracks in-flight destination registers, selects forwarding
// sources, and raises stall/bubble for load-use (or any RAW hazard in stall-only mode).
module hazard_scoreboard
   import hazard_scoreboard_pkg::*;
#(
   parameter int unsigned NREG   = 8,
   parameter int unsigned DEPTH  = 3,
   parameter int unsigned FWD_EN = 1,
   localparam int unsigned AW    = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          issue,
   input  logic [AW-1:0] rs_addr,
   input  logic [AW-1:0] rt_addr,
   input  logic          rs_used,
   input  logic          rt_used,
   input  logic [AW-1:0] rd_addr,
   input  logic          rd_wr,
   input  logic          is_load,
   input  logic          flush,
   input  logic          hold,
   output logic          stall,
   output logic          bubble,
   output logic [1:0]    fwd_rs_sel,
   output logic [1:0]    fwd_rt_sel,
   output logic [15:0]   stall_cnt
);

   stage_entry_t [DEPTH-1:0] stages_q, stages_d;
   logic [15:0]              stall_cnt_q, stall_cnt_d;
   logic                     rs_hazard, rt_hazard;

   hz_match #(
      .DEPTH  (DEPTH),
      .FWD_EN (FWD_EN)
   ) u_rs_match (
      .stages (stages_q),
      .addr   (RD_W'(rs_addr)),
      .used   (rs_used),
      .hazard (rs_hazard),
      .sel    (fwd_rs_sel)
   );

   hz_match #(
      .DEPTH  (DEPTH),
      .FWD_EN (FWD_EN)
   ) u_rt_match (
      .stages (stages_q),
      .addr   (RD_W'(rt_addr)),
      .used   (rt_used),
      .hazard (rt_hazard),
      .sel    (fwd_rt_sel)
   );

   // A flush kills the decode instruction, so its hazard no longer matters.
   assign stall     = (issue & (rs_hazard | rt_hazard) & ~flush) | hold;
   assign bubble    = ~hold & (stall | flush | ~issue);
   assign stall_cnt = stall_cnt_q;

   always_comb begin
      stages_d    = stages_q;
      stall_cnt_d = stall_cnt_q;
      if (!hold) begin
         stages_d[0] = '{valid: issue & rd_wr & ~stall & ~flush,
                         rd:    RD_W'(rd_addr),
                         load:  is_load};
         // The branch shadow instruction sitting in stage 0 is squashed on its way out.
         stages_d[1] = flush ? '0 : stages_q[0];
         for (int i = 2; i < int'(DEPTH); i++) begin
            stages_d[i] = stages_q[i-1];
         end
         if (issue && stall && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stages_q    <= '0;
         stall_cnt_q <= '0;
      end else begin
         stages_q    <= stages_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: directed cycles push hand-computed expectations, a negedge monitor pops
// and compares them against one of three scoreboard configurations.
module tb_hazard_scoreboard;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic rst_next = 1'b0;
   logic issue = 1'b0, rs_used = 1'b0, rt_used = 1'b0, rd_wr = 1'b0, is_load = 1'b0;
   logic flush = 1'b0, hold = 1'b0;
   logic [2:0] rs_addr = '0, rt_addr = '0, rd_addr = '0;

   logic [2:0]       stall_w, bubble_w;
   logic [2:0][1:0]  rs_sel_w, rt_sel_w;
   logic [2:0][15:0] cnt_w;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string name;
      int    dut;
      int    stall, bubble, rs, rt, cnt;   // -1 = don't care
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   // 0: forwarding, 1: stall-only, 2: stall-only deep pipe for counter saturation
   hazard_scoreboard #(.NREG(8), .DEPTH(3), .FWD_EN(1)) u_fwd (
      .clk(clk), .rst_n(rst_n), .issue(issue), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rs_used(rs_used), .rt_used(rt_used), .rd_addr(rd_addr), .rd_wr(rd_wr),
      .is_load(is_load), .flush(flush), .hold(hold), .stall(stall_w[0]),
      .bubble(bubble_w[0]), .fwd_rs_sel(rs_sel_w[0]), .fwd_rt_sel(rt_sel_w[0]),
      .stall_cnt(cnt_w[0])
   );

   hazard_scoreboard #(.NREG(8), .DEPTH(3), .FWD_EN(0)) u_stall (
      .clk(clk), .rst_n(rst_n), .issue(issue), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rs_used(rs_used), .rt_used(rt_used), .rd_addr(rd_addr), .rd_wr(rd_wr),
      .is_load(is_load), .flush(flush), .hold(hold), .stall(stall_w[1]),
      .bubble(bubble_w[1]), .fwd_rs_sel(rs_sel_w[1]), .fwd_rt_sel(rt_sel_w[1]),
      .stall_cnt(cnt_w[1])
   );

   hazard_scoreboard #(.NREG(8), .DEPTH(256), .FWD_EN(0)) u_sat (
      .clk(clk), .rst_n(rst_n), .issue(issue), .rs_addr(rs_addr), .rt_addr(rt_addr),
      .rs_used(rs_used), .rt_used(rt_used), .rd_addr(rd_addr), .rd_wr(rd_wr),
      .is_load(is_load), .flush(flush), .hold(hold), .stall(stall_w[2]),
      .bubble(bubble_w[2]), .fwd_rs_sel(rs_sel_w[2]), .fwd_rt_sel(rt_sel_w[2]),
      .stall_cnt(cnt_w[2])
   );

   task automatic drv(input int iss, input int rs, input int rsu, input int rt, input int rtu,
                      input int rd, input int rdw, input int ld, input int fl, input int hd);
      @(posedge clk);
      #1;
      rst_n   = rst_next;
      issue   = 1'(iss);
      rs_addr = 3'(rs);
      rs_used = 1'(rsu);
      rt_addr = 3'(rt);
      rt_used = 1'(rtu);
      rd_addr = 3'(rd);
      rd_wr   = 1'(rdw);
      is_load = 1'(ld);
      flush   = 1'(fl);
      hold    = 1'(hd);
   endtask

   // Inputs: issue rs rs_used rt rt_used rd rd_wr is_load flush hold
   // Expect: stall bubble fwd_rs_sel fwd_rt_sel stall_cnt
   task automatic cyc(input string nm, input int d,
                      input int iss, input int rs, input int rsu, input int rt, input int rtu,
                      input int rd, input int rdw, input int ld, input int fl, input int hd,
                      input int es, input int eb, input int ers, input int ert, input int ecnt);
      drv(iss, rs, rsu, rt, rtu, rd, rdw, ld, fl, hd);
      q.push_back('{name: nm, dut: d, stall: es, bubble: eb, rs: ers, rt: ert, cnt: ecnt});
   endtask

   task automatic chk(input string nm, input string fld, input int act, input int req);
      if (req >= 0) begin
         checks++;
         if (act != req) begin
            errors++;
            $display("FAIL %s.%s actual=%0d required=%0d", nm, fld, act, req);
         end
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         chk(e.name, "stall",  int'(stall_w[e.dut]),  e.stall);
         chk(e.name, "bubble", int'(bubble_w[e.dut]), e.bubble);
         chk(e.name, "rs_sel", int'(rs_sel_w[e.dut]), e.rs);
         chk(e.name, "rt_sel", int'(rt_sel_w[e.dut]), e.rt);
         chk(e.name, "cnt",    int'(cnt_w[e.dut]),    e.cnt);
      end
   end

   initial begin
      // Forwarding configuration
      cyc("rst_idle",   0, 0,0,0,0,0, 0,0,0,0,0,  0,1, 0,0,0);
      cyc("rst_hold",   0, 0,3,1,0,0, 0,0,0,0,1,  1,0, 0,0,0);
      rst_next = 1'b1;
      cyc("add_r3",     0, 1,0,0,0,0, 3,1,0,0,0,  0,0, 0,0,0);
      cyc("ex_fwd",     0, 1,3,1,0,0, 6,1,0,0,0,  0,0, 1,0,0);
      cyc("mem_ex",     0, 0,3,1,6,1, 0,0,0,0,0,  0,1, 2,1,0);
      cyc("wb_mem",     0, 0,3,1,6,1, 0,0,0,0,0,  0,1, 3,2,0);
      cyc("rf_wb",      0, 0,3,1,6,1, 0,0,0,0,0,  0,1, 0,3,0);
      cyc("ld_r2",      0, 1,0,0,0,0, 2,1,1,0,0,  0,0, 0,0,0);
      cyc("ld_use",     0, 1,0,0,2,1, 7,1,0,0,0,  1,1, 0,-1,0);
      cyc("ld_mem",     0, 1,0,0,2,1, 7,1,0,0,0,  0,0, 0,2,1);
      cyc("ld_wb",      0, 0,7,1,2,1, 0,0,0,0,0,  0,1, 1,3,1);
      cyc("add_r4a",    0, 1,0,0,0,0, 4,1,0,0,0,  0,0, 0,0,1);
      cyc("add_r5",     0, 1,0,0,0,0, 5,1,0,0,0,  0,0, 0,0,1);
      cyc("add_r4b",    0, 1,4,1,0,0, 4,1,0,0,0,  0,0, 2,0,1);
      cyc("youngest",   0, 1,4,1,5,1, 0,0,0,0,0,  0,0, 1,2,1);
      cyc("ld_r1",      0, 1,0,0,0,0, 1,1,1,0,0,  0,0, 0,0,1);
      for (int i = 0; i < 5; i++) begin
         cyc("hold_frz", 0, 1,1,1,0,0, 0,0,0,0,1,  1,0, -1,0,1);
      end
      cyc("hold_rel",   0, 1,1,1,0,0, 0,0,0,0,0,  1,1, -1,0,1);
      cyc("hold_mem",   0, 1,1,1,0,0, 0,0,0,0,0,  0,0, 2,0,2);
      cyc("ld_r3",      0, 1,0,0,0,0, 3,1,1,0,0,  0,0, 0,0,2);
      cyc("flush_ld",   0, 1,3,1,0,0, 0,0,0,1,0,  0,1, -1,0,2);
      cyc("flush_kill", 0, 0,3,1,0,0, 0,0,0,0,0,  0,1, 0,0,2);
      cyc("add_r6",     0, 1,0,0,0,0, 6,1,0,0,0,  0,0, 0,0,2);
      cyc("hold_flush", 0, 1,6,1,0,0, 0,0,0,1,1,  1,0, 1,0,2);
      cyc("flush_ign",  0, 1,6,1,0,0, 0,0,0,0,0,  0,0, 1,0,2);
      cyc("ld_r2b",     0, 1,0,0,0,0, 2,1,1,0,0,  0,0, 0,0,2);
      cyc("rst_pend",   0, 1,0,0,2,1, 0,0,0,0,0,  1,1, 0,-1,2);
      rst_next = 1'b0;
      cyc("rst_async",  0, 1,0,0,2,1, 0,0,0,0,0,  0,0, 0,0,0);
      rst_next = 1'b1;
      cyc("post_rst",   0, 1,0,0,2,1, 0,0,0,0,0,  0,0, 0,0,0);

      // Stall-only configuration
      rst_next = 1'b0;
      cyc("s_rst",      1, 0,0,0,0,0, 0,0,0,0,0,  0,1, 0,0,0);
      rst_next = 1'b1;
      cyc("s_add_r5",   1, 1,0,0,0,0, 5,1,0,0,0,  0,0, 0,0,0);
      cyc("s_use0",     1, 1,5,1,0,0, 5,1,0,0,0,  1,1, 0,0,0);
      cyc("s_use1",     1, 1,5,1,0,0, 5,1,0,0,0,  1,1, 0,0,1);
      cyc("s_use2",     1, 1,5,1,0,0, 5,1,0,0,0,  1,1, 0,0,2);
      cyc("s_go",       1, 1,5,1,0,0, 5,1,0,0,0,  0,0, 0,0,3);
      cyc("s_unused",   1, 1,5,0,5,0, 0,0,0,0,0,  0,0, 0,0,3);

      // Saturation: ADD r1,r1 back-to-back proceeds once per 257 cycles with DEPTH=256,
      // so 256*257 cycles give 65536 stalled cycles, one past the counter ceiling.
      rst_next = 1'b0;
      drv(0,0,0,0,0, 0,0,0,0,0);
      rst_next = 1'b1;
      for (int i = 0; i < 256 * 257; i++) begin
         drv(1,1,1,0,0, 1,1,0,0,0);
      end
      cyc("sat_go",     2, 1,1,1,0,0, 1,1,0,0,0,  0,0, 0,0,65535);
      for (int i = 0; i < 3; i++) begin
         cyc("sat_hold", 2, 1,1,1,0,0, 1,1,0,0,0,  1,1, 0,0,65535);
      end

      for (int k = 0; k < 4 && q.size() > 0; k++) @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain pending=%0d required=0", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
